// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit common-anode FND display.
// Segment fonts are 7-bit {g,f,e,d,c,b,a}, active-low; the decimal point
// is handled separately by the top. Digit enables are active-low one-hot.
package fnd_pkg;

  localparam logic [6:0] FONT_0     = 7'h40;
  localparam logic [6:0] FONT_1     = 7'h79;
  localparam logic [6:0] FONT_2     = 7'h24;
  localparam logic [6:0] FONT_3     = 7'h30;
  localparam logic [6:0] FONT_4     = 7'h19;
  localparam logic [6:0] FONT_5     = 7'h12;
  localparam logic [6:0] FONT_6     = 7'h02;
  localparam logic [6:0] FONT_7     = 7'h78;
  localparam logic [6:0] FONT_8     = 7'h00;
  localparam logic [6:0] FONT_9     = 7'h10;
  localparam logic [6:0] FONT_BLANK = 7'h7F;

  // Full 8-bit pattern with the decimal point also dark.
  localparam logic [7:0] FONT_OFF   = 8'hFF;

  localparam logic [3:0] DIG_0      = 4'b1110;
  localparam logic [3:0] DIG_1      = 4'b1101;
  localparam logic [3:0] DIG_2      = 4'b1011;
  localparam logic [3:0] DIG_3      = 4'b0111;
  localparam logic [3:0] DIG_NONE   = 4'b1111;

endpackage

// File: rtl/fnd_select_decoder.sv
// Combinational digit-select decoder.
// Ports:
//   i_sel   [1:0] : digit slot currently being scanned
//   i_en          : display enable; 0 turns every digit off
//   o_digit [3:0] : active-low one-hot digit enable (bit n = digit n)
module fnd_select_decoder
  import fnd_pkg::*;
(
  input  logic [1:0] i_sel,
  input  logic       i_en,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = DIG_NONE;
    if (i_en) begin
      case (i_sel)
        2'd0: o_digit = DIG_0;
        2'd1: o_digit = DIG_1;
        2'd2: o_digit = DIG_2;
        2'd3: o_digit = DIG_3;
      endcase
    end
  end

endmodule

// File: rtl/bcd_to_fnd_decoder.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler divides i_clk by SCAN_DIV; each wrap advances the digit slot.
// Outputs are registered, so they follow select/input changes by one cycle.
// Ports:
//   i_clk          : system clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   i_en           : display enable; 0 blanks digits and segments
//   i_value [15:0] : four BCD digits, [3:0] = digit 0 (rightmost)
//   i_dp    [3:0]  : decimal point per digit, 1 = lit
//   o_digit [3:0]  : active-low one-hot digit enables
//   o_font  [7:0]  : active-low segments {dp,g,f,e,d,c,b,a}
module bcd_to_fnd_decoder
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  output logic [3:0]  o_digit,
  output logic [7:0]  o_font
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic [1:0]       sel;
  logic             tick;
  logic [3:0]       nibble;
  logic             dp_sel;
  logic [6:0]       seg;
  logic [3:0]       digit_dec;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = FONT_0;
      4'd1:    s = FONT_1;
      4'd2:    s = FONT_2;
      4'd3:    s = FONT_3;
      4'd4:    s = FONT_4;
      4'd5:    s = FONT_5;
      4'd6:    s = FONT_6;
      4'd7:    s = FONT_7;
      4'd8:    s = FONT_8;
      4'd9:    s = FONT_9;
      default: s = FONT_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    tick = (presc == CNT_LAST);
  end

  always_comb begin
    nibble = i_value[3:0];
    dp_sel = i_dp[0];
    case (sel)
      2'd0: begin nibble = i_value[3:0];   dp_sel = i_dp[0]; end
      2'd1: begin nibble = i_value[7:4];   dp_sel = i_dp[1]; end
      2'd2: begin nibble = i_value[11:8];  dp_sel = i_dp[2]; end
      2'd3: begin nibble = i_value[15:12]; dp_sel = i_dp[3]; end
    endcase
    seg = bcd_to_seg(nibble);
  end

  fnd_select_decoder u_sel_dec (
    .i_sel   (sel),
    .i_en    (i_en),
    .o_digit (digit_dec)
  );

  // Scan keeps running with i_en low so re-enabling resumes mid-scan.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc   <= '0;
      sel     <= '0;
      o_digit <= DIG_NONE;
      o_font  <= FONT_OFF;
    end else begin
      presc   <= tick ? '0 : presc + 1'b1;
      sel     <= tick ? sel + 2'd1 : sel;
      o_digit <= digit_dec;
      o_font  <= i_en ? {~dp_sel, seg} : FONT_OFF;
    end
  end

endmodule

// File: tb/tb_bcd_to_fnd_decoder.sv
// Self-checking bench for bcd_to_fnd_decoder with a short scan period,
// plus stand-alone checks of fnd_select_decoder.
module tb_bcd_to_fnd_decoder;

  localparam int unsigned DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  o_digit;
  logic [7:0]  o_font;

  logic [1:0]  sd_sel;
  logic        sd_en;
  logic [3:0]  sd_digit;

  int unsigned total;
  int unsigned bad;
  int unsigned cyc;      // clock edges since reset release
  logic [7:0]  font_tbl [16];

  bcd_to_fnd_decoder #(.SCAN_DIV(DIV)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_value (value),
    .i_dp    (dp),
    .o_digit (o_digit),
    .o_font  (o_font)
  );

  fnd_select_decoder u_sd (
    .i_sel   (sd_sel),
    .i_en    (sd_en),
    .o_digit (sd_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: the slot shown after an edge is the slot in force before it,
  // which is the number of whole scan periods elapsed, modulo four digits.
  task automatic step(input string tag, input logic e, input logic [15:0] v, input logic [3:0] d);
    int unsigned s;
    logic [3:0]  nib;
    logic [3:0]  exp_dig;
    logic [7:0]  exp_font;
    en = e; value = v; dp = d;
    s = (cyc / DIV) % 4;
    @(posedge clk);
    #1;
    cyc++;
    nib = 4'((v >> (4 * s)) & 16'hF);
    if (e) begin
      exp_dig  = ~(4'b0001 << s);
      exp_font = {~d[s], font_tbl[nib][6:0]};
    end else begin
      exp_dig  = 4'hF;
      exp_font = 8'hFF;
    end
    check4({tag, "_digit"}, o_digit, exp_dig);
    check8({tag, "_font"}, o_font, exp_font);
  endtask

  initial begin
    font_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; en = 1'b0; value = '0; dp = '0;
    sd_sel = '0; sd_en = 1'b0;

    // Reset state
    #12;
    check4("rst_digit", o_digit, 4'hF);
    check8("rst_font", o_font, 8'hFF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;

    // Full scan of 1234, two complete rounds; first edge shows digit 0
    for (int i = 0; i < 2 * 4 * DIV; i++) step("scan", 1'b1, 16'h1234, 4'h0);
    // Directed spot-check of the first slot constants after a fresh round start
    // (cyc is now a multiple of 4*DIV, so slot 0 = digit 0 '4' = 99)
    step("scan_d0", 1'b1, 16'h1234, 4'h0);
    check4("scan_d0_const", o_digit, 4'b1110);
    check8("scan_d0_font_const", o_font, 8'h99);

    // Enable gating: blank mid-scan, then resume at the current slot
    for (int i = 0; i < 6; i++) step("gate_off", 1'b0, 16'h5678, 4'hF);
    for (int i = 0; i < 6; i++) step("gate_on", 1'b1, 16'h5678, 4'hF);

    // All codes 0-F, every digit carrying the code so any slot shows it
    for (int c = 0; c < 16; c++) begin
      for (int r = 0; r < 2; r++) step("code", 1'b1, {4{4'(c)}}, 4'h0);
    end

    // Decimal points on digits 0 and 2 with all-eights
    for (int i = 0; i < 4 * DIV; i++) step("dp", 1'b1, 16'h8888, 4'b0101);

    // Reset mid-scan: outputs forced immediately, then restart at digit 0
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 16'h9876, 4'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check4("midrst_digit", o_digit, 4'hF);
    check8("midrst_font", o_font, 8'hFF);
    @(posedge clk); #1;
    check4("midrst_hold_digit", o_digit, 4'hF);
    check8("midrst_hold_font", o_font, 8'hFF);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 4 * DIV + 2; i++) step("post_rst", 1'b1, 16'h9876, 4'h2);

    // Randomized traffic, including invalid codes and enable toggling
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 7) != 0), 16'($urandom), 4'($urandom));

    // Select decoder stand-alone
    for (int e = 0; e < 2; e++) begin
      for (int s = 0; s < 4; s++) begin
        sd_en = 1'(e); sd_sel = 2'(s);
        #1;
        check4("seldec", sd_digit, (e != 0) ? ~(4'b0001 << s) : 4'hF);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
